// File: rtl/interrupt_sequencer.sv
// Interrupt request consumer: pin synchronisers, NMI edge latch, IRQ poll sampling,
// and the reset/NMI/IRQ/BRK sequencing handshake with the core.

module interrupt_sequencer_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  logic [STAGES-1:0] sr;

  // Flops come out of reset deasserted (pins are active low).
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '1;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < STAGES; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[STAGES-1];
endmodule

module interrupt_sequencer #(
  parameter int P_sync_stages = 2
) (
  input  logic       I_clock,
  input  logic       I_reset,
  input  logic       I_nmi_n,
  input  logic       I_irq_n,
  input  logic       I_irq_mask,
  input  logic       I_poll,
  input  logic       I_brk,
  input  logic       I_start,
  input  logic       I_vector_fetch,
  input  logic       I_ack,
  output logic       O_pending,
  output logic       O_active,
  output logic [7:0] O_vector,
  output logic       O_b_flag,
  output logic       O_write_inhibit,
  output logic       O_nmi_latched
);
  localparam int NUM_PINS = 2;

  localparam logic [1:0] S_RESET    = 2'd0;
  localparam logic [1:0] S_IDLE     = 2'd1;
  localparam logic [1:0] S_PENDING  = 2'd2;
  localparam logic [1:0] S_SEQUENCE = 2'd3;

  localparam logic [7:0] VEC_NMI   = 8'hFA;
  localparam logic [7:0] VEC_RESET = 8'hFC;
  localparam logic [7:0] VEC_IRQ   = 8'hFE;

  logic [NUM_PINS-1:0] pin_raw;
  logic [NUM_PINS-1:0] pin_sync;

  logic [1:0] state;
  logic       nmi_sync;
  logic       irq_sync;
  logic       nmi_prev;
  logic       nmi_edge;
  logic       nmi_latch;
  logic       nmi_clear;
  logic       irq_req;
  logic       reset_seq;
  logic       b_flag;
  logic [7:0] vector;

  assign pin_raw = {I_irq_n, I_nmi_n};

  for (genvar g = 0; g < NUM_PINS; g++) begin : g_sync
    interrupt_sequencer_sync #(.STAGES(P_sync_stages)) u_sync (
      .clk  (I_clock),
      .rst  (I_reset),
      .din  (pin_raw[g]),
      .dout (pin_sync[g])
    );
  end

  assign nmi_sync = pin_sync[0];
  assign irq_sync = pin_sync[1];

  // nmi_prev resets high with the synchronisers, so reset release never fakes an edge.
  assign nmi_edge  = nmi_prev & ~nmi_sync;
  assign irq_req   = ~irq_sync & ~I_irq_mask;
  assign nmi_clear = (state == S_SEQUENCE) & I_vector_fetch & ~reset_seq & nmi_latch;

  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      state     <= S_RESET;
      nmi_prev  <= 1'b1;
      nmi_latch <= 1'b0;
      reset_seq <= 1'b1;
      b_flag    <= 1'b0;
      vector    <= VEC_RESET;
    end else begin
      nmi_prev  <= nmi_sync;
      nmi_latch <= (nmi_latch & ~nmi_clear) | nmi_edge;
      case (state)
        S_RESET: begin
          if (I_start) begin
            state     <= S_SEQUENCE;
            reset_seq <= 1'b1;
            b_flag    <= 1'b0;
          end
        end
        S_IDLE: begin
          if (I_poll && (nmi_latch || irq_req)) begin
            state <= S_PENDING;
          end else if (I_brk) begin
            state  <= S_SEQUENCE;
            b_flag <= 1'b1;
          end
        end
        S_PENDING: begin
          if (I_start) begin
            state  <= S_SEQUENCE;
            b_flag <= 1'b0;
          end
        end
        default: begin
          // A latched NMI hijacks BRK/IRQ at the vector read; b_flag is left alone.
          if (I_vector_fetch) begin
            if (reset_seq)      vector <= VEC_RESET;
            else if (nmi_latch) vector <= VEC_NMI;
            else                vector <= VEC_IRQ;
          end
          if (I_ack) begin
            state     <= S_IDLE;
            reset_seq <= 1'b0;
          end
        end
      endcase
    end
  end

  assign O_pending       = (state == S_RESET) || (state == S_PENDING);
  assign O_active        = (state == S_SEQUENCE);
  assign O_vector        = vector;
  assign O_b_flag        = b_flag;
  assign O_write_inhibit = reset_seq;
  assign O_nmi_latched   = nmi_latch;
endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench: stimulus queues hand-computed output snapshots with a due cycle,
// a negedge monitor compares them when the cycle arrives.

module tb_interrupt_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       nmi_n = 1'b1, irq_n = 1'b1, irq_mask = 1'b1;
  logic       poll = 1'b0, brk = 1'b0, start = 1'b0, vfetch = 1'b0, ack = 1'b0;
  logic       pending, active, b_flag, write_inhibit, nmi_latched;
  logic [7:0] vector;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    string       name;
    logic [12:0] exp;
  } exp_t;

  exp_t sb[$];

  interrupt_sequencer #(.P_sync_stages(2)) dut (
    .I_clock         (clk),
    .I_reset         (rst),
    .I_nmi_n         (nmi_n),
    .I_irq_n         (irq_n),
    .I_irq_mask      (irq_mask),
    .I_poll          (poll),
    .I_brk           (brk),
    .I_start         (start),
    .I_vector_fetch  (vfetch),
    .I_ack           (ack),
    .O_pending       (pending),
    .O_active        (active),
    .O_vector        (vector),
    .O_b_flag        (b_flag),
    .O_write_inhibit (write_inhibit),
    .O_nmi_latched   (nmi_latched)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // {pending, active, vector, b_flag, write_inhibit, nmi_latched}
  function automatic logic [12:0] snap(logic p, logic a, logic [7:0] v, logic b, logic w, logic n);
    return {p, a, v, b, w, n};
  endfunction

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(int ofs, string name, logic [12:0] e);
    exp_t x;
    x.due = cyc + ofs;
    x.name = name;
    x.exp = e;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    logic [12:0] act;
    act = {pending, active, vector, b_flag, write_inhibit, nmi_latched};
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        checks++;
        if (act !== sb[i].exp) begin
          errors++;
          $display("FAIL %s cyc=%0d got p=%b a=%b v=%h b=%b wi=%b n=%b want p=%b a=%b v=%h b=%b wi=%b n=%b",
                   sb[i].name, cyc, act[12], act[11], act[10:3], act[2], act[1], act[0],
                   sb[i].exp[12], sb[i].exp[11], sb[i].exp[10:3], sb[i].exp[2], sb[i].exp[1], sb[i].exp[0]);
        end
        sb.delete(i);
      end else if (sb[i].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s missed due=%0d now=%0d", sb[i].name, sb[i].due, cyc);
        sb.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state and the reset sequence
    tick(2);
    expect_at(0, "rst_state", snap(1, 0, 8'hFC, 0, 1, 0));
    rst = 1'b0;
    tick();
    expect_at(0, "rst_release", snap(1, 0, 8'hFC, 0, 1, 0));
    start = 1; expect_at(1, "rst_start", snap(0, 1, 8'hFC, 0, 1, 0)); tick(); start = 0;
    vfetch = 1; expect_at(1, "rst_vf", snap(0, 1, 8'hFC, 0, 1, 0)); tick(); vfetch = 0;
    ack = 1; expect_at(1, "rst_ack", snap(0, 0, 8'hFC, 0, 0, 0)); tick(); ack = 0;
    start = 1; expect_at(1, "start_ign", snap(0, 0, 8'hFC, 0, 0, 0)); tick(); start = 0;

    // NMI: pin fall -> latch after 3 cycles, poll -> pending
    nmi_n = 0;
    expect_at(2, "nmi_not_yet", snap(0, 0, 8'hFC, 0, 0, 0));
    expect_at(3, "nmi_latch", snap(0, 0, 8'hFC, 0, 0, 1));
    tick(4);
    poll = 1; expect_at(1, "nmi_poll", snap(1, 0, 8'hFC, 0, 0, 1)); tick(); poll = 0;
    nmi_n = 1;
    start = 1; expect_at(1, "nmi_start", snap(0, 1, 8'hFC, 0, 0, 1)); tick(); start = 0;
    vfetch = 1; expect_at(1, "nmi_vf", snap(0, 1, 8'hFA, 0, 0, 0)); tick(); vfetch = 0;
    ack = 1; expect_at(1, "nmi_ack", snap(0, 0, 8'hFA, 0, 0, 0)); tick(); ack = 0;

    // IRQ masked, then unmasked; deassert before fetch
    irq_n = 0;
    tick(3);
    poll = 1; expect_at(1, "irq_masked", snap(0, 0, 8'hFA, 0, 0, 0)); tick(); poll = 0;
    irq_mask = 0;
    poll = 1; expect_at(1, "irq_poll", snap(1, 0, 8'hFA, 0, 0, 0)); tick(); poll = 0;
    irq_n = 1; irq_mask = 1;
    start = 1; expect_at(1, "irq_start", snap(0, 1, 8'hFA, 0, 0, 0)); tick(); start = 0;
    tick(3);
    vfetch = 1; expect_at(1, "irq_vf", snap(0, 1, 8'hFE, 0, 0, 0)); tick(); vfetch = 0;
    ack = 1; expect_at(1, "irq_ack", snap(0, 0, 8'hFE, 0, 0, 0)); tick(); ack = 0;

    // BRK hijacked by NMI
    brk = 1; expect_at(1, "brk", snap(0, 1, 8'hFE, 1, 0, 0)); tick(); brk = 0;
    nmi_n = 0;
    expect_at(3, "brk_nmi_lat", snap(0, 1, 8'hFE, 1, 0, 1));
    tick(3);
    vfetch = 1; expect_at(1, "hijack_vf", snap(0, 1, 8'hFA, 1, 0, 0)); tick(); vfetch = 0;
    ack = 1; expect_at(1, "hijack_ack", snap(0, 0, 8'hFA, 1, 0, 0)); tick(); ack = 0;
    nmi_n = 1;
    tick(3);

    // New NMI edge in the same cycle as the clearing vector fetch
    nmi_n = 0;
    expect_at(3, "nmi2_lat", snap(0, 0, 8'hFA, 1, 0, 1));
    tick(3);
    nmi_n = 1;
    poll = 1; expect_at(1, "nmi2_poll", snap(1, 0, 8'hFA, 1, 0, 1)); tick(); poll = 0;
    start = 1; expect_at(1, "nmi2_start", snap(0, 1, 8'hFA, 0, 0, 1)); tick(); start = 0;
    nmi_n = 0;
    tick(2);
    vfetch = 1; expect_at(1, "edge_vs_clear", snap(0, 1, 8'hFA, 0, 0, 1)); tick(); vfetch = 0;
    ack = 1; expect_at(1, "nmi2_ack", snap(0, 0, 8'hFA, 0, 0, 1)); tick(); ack = 0;
    poll = 1; expect_at(1, "nmi3_poll", snap(1, 0, 8'hFA, 0, 0, 1)); tick(); poll = 0;
    start = 1; expect_at(1, "nmi3_start", snap(0, 1, 8'hFA, 0, 0, 1)); tick(); start = 0;
    vfetch = 1; expect_at(1, "nmi3_vf", snap(0, 1, 8'hFA, 0, 0, 0)); tick(); vfetch = 0;
    ack = 1; expect_at(1, "nmi3_ack", snap(0, 0, 8'hFA, 0, 0, 0)); tick(); ack = 0;
    nmi_n = 1;
    tick(3);

    // Poll with a request beats a same-cycle BRK; BRK ignored while pending
    irq_n = 0; irq_mask = 0;
    tick(3);
    poll = 1; brk = 1; expect_at(1, "poll_over_brk", snap(1, 0, 8'hFA, 0, 0, 0)); tick(); poll = 0; brk = 0;
    brk = 1; expect_at(1, "brk_ign", snap(1, 0, 8'hFA, 0, 0, 0)); tick(); brk = 0;
    start = 1; expect_at(1, "pb_start", snap(0, 1, 8'hFA, 0, 0, 0)); tick(); start = 0;
    vfetch = 1; expect_at(1, "pb_vf", snap(0, 1, 8'hFE, 0, 0, 0)); tick(); vfetch = 0;
    irq_n = 1; irq_mask = 1;
    ack = 1; expect_at(1, "pb_ack", snap(0, 0, 8'hFE, 0, 0, 0)); tick(); ack = 0;
    tick(3);

    // Reset mid-sequence with NMI latched
    brk = 1; expect_at(1, "brk2", snap(0, 1, 8'hFE, 1, 0, 0)); tick(); brk = 0;
    nmi_n = 0;
    expect_at(3, "brk2_nmi_lat", snap(0, 1, 8'hFE, 1, 0, 1));
    tick(3);
    rst = 1; nmi_n = 1;
    expect_at(1, "rst_mid", snap(1, 0, 8'hFC, 0, 1, 0)); tick(); rst = 0;
    start = 1; expect_at(1, "rst2_start", snap(0, 1, 8'hFC, 0, 1, 0)); tick(); start = 0;
    vfetch = 1; expect_at(1, "rst2_vf", snap(0, 1, 8'hFC, 0, 1, 0)); tick(); vfetch = 0;
    ack = 1; expect_at(1, "rst2_ack", snap(0, 0, 8'hFC, 0, 0, 0)); tick(); ack = 0;
    tick(3);
    poll = 1; expect_at(1, "no_stale_nmi", snap(0, 0, 8'hFC, 0, 0, 0)); tick(); poll = 0;

    tick(3);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
